// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 constants, host-transmit FSM states and parity helper
//
// Contents:
//   PS2_FILTER_LEN  consecutive equal samples needed before a filtered line changes
//   PS2_FRAME_BITS  start + 8 data + parity + stop
//   ps2_tx_state_e  host-transmit FSM states
//   ps2_odd_parity  odd parity bit for one data byte
package ps2_pkg;

  localparam int PS2_FILTER_LEN = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_FAIL
  } ps2_tx_state_e;

  // Odd parity: the parity bit makes the total count of ones (data + parity) odd.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchroniser, glitch filter and falling-edge detector
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   line_in    raw, asynchronous pad level
//   line_level filtered level (idles high, as the bus does)
//   line_fall  1-cycle pulse on a filtered high-to-low transition
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_level,
  output logic line_fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             line_meta;
  logic             line_sync;
  logic [CNT_W-1:0] run_cnt;

  // run_cnt counts consecutive synchronised samples that disagree with the
  // filtered level; the level flips on the FILTER_LEN-th such sample, so any
  // shorter excursion is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_meta  <= 1'b1;
      line_sync  <= 1'b1;
      line_level <= 1'b1;
      line_fall  <= 1'b0;
      run_cnt    <= '0;
    end else begin
      line_meta <= line_in;
      line_sync <= line_meta;
      line_fall <= 1'b0;
      if (line_sync == line_level) begin
        run_cnt <= '0;
      end else if (run_cnt == CNT_LAST) begin
        line_level <= line_sync;
        line_fall  <= line_level;
        run_cnt    <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter (open-drain pull-low enables)
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   ps2clk_in, ps2data_in   raw pad levels (asynchronous)
//   ps2clk_oe, ps2data_oe   1 = pull pad low, 0 = release
//   tx_data, tx_start       command byte and single-cycle start (accepted only when idle)
//   busy                    high from the accepted start until the frame ends
//   done                    1-cycle pulse: frame sent and device ACK seen
//   error                   1-cycle pulse: ACK missing or frame timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLKFREQ_KHZ = 28000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_MS  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_CYC = CLKFREQ_KHZ * INHIBIT_US / 1000;
  localparam int TO_CYC  = CLKFREQ_KHZ * TIMEOUT_MS;
  localparam int INH_W   = $clog2(INH_CYC);
  localparam int TO_W    = $clog2(TO_CYC);
  localparam int BIT_W   = $clog2(PS2_FRAME_BITS);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);
  // The tenth fall inside SEND is the stop-bit fall.
  localparam logic [BIT_W-1:0] STOP_FALL = BIT_W'(PS2_FRAME_BITS - 2);

  ps2_tx_state_e    state, state_d;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [BIT_W-1:0] bitcnt;
  logic [9:0]       shreg;    // {stop, parity, D7..D0}, shifted out LSB first
  logic             cur_bit;  // bit currently presented on the data line
  logic             clk_level;
  logic             clk_fall;
  logic             data_meta;
  logic             data_sync;
  logic             timeout;
  logic             timed_state;

  ps2_line_filter #(
    .FILTER_LEN(PS2_FILTER_LEN)
  ) u_clk_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_in   (ps2clk_in),
    .line_level(clk_level),
    .line_fall (clk_fall)
  );

  // Data only needs metastability protection: it is sampled on filtered clock
  // falls, long after it has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2data_in;
      data_sync <= data_meta;
    end
  end

  assign timed_state = (state == ST_REQ) || (state == ST_SEND) ||
                       (state == ST_ACK) || (state == ST_WAIT_IDLE);
  assign timeout     = timed_state && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Outputs decode from the registered state so an asynchronous reset
  // releases both pads without waiting for a clock edge.
  always_comb begin
    state_d    = state;
    ps2clk_oe  = 1'b0;
    ps2data_oe = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (tx_start) state_d = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        ps2clk_oe = 1'b1;
        if (inh_cnt == INH_LAST) state_d = ST_REQ;
      end
      ST_REQ: begin
        ps2data_oe = 1'b1;
        if (timeout)       state_d = ST_FAIL;
        else if (clk_fall) state_d = ST_SEND;
      end
      ST_SEND: begin
        ps2data_oe = ~cur_bit;
        if (timeout)                                state_d = ST_FAIL;
        else if (clk_fall && bitcnt == STOP_FALL)   state_d = ST_ACK;
      end
      ST_ACK: begin
        if (timeout)       state_d = ST_FAIL;
        else if (clk_fall) state_d = data_sync ? ST_FAIL : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (timeout) begin
          state_d = ST_FAIL;
        end else if (clk_level && data_sync) begin
          done    = 1'b1;
          busy    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_FAIL: begin
        busy    = 1'b0;
        error   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_cnt <= '0;
      to_cnt  <= '0;
      bitcnt  <= '0;
      shreg   <= '1;
      cur_bit <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          inh_cnt <= '0;
          if (tx_start) shreg <= {1'b1, ps2_odd_parity(tx_data), tx_data};
        end
        ST_INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          to_cnt  <= '0;
          bitcnt  <= '0;
          cur_bit <= 1'b0;
        end
        ST_REQ: begin
          bitcnt  <= '0;
          cur_bit <= 1'b0;
        end
        ST_SEND: begin
          if (clk_fall) begin
            bitcnt  <= bitcnt + 1'b1;
            cur_bit <= shreg[0];
            shreg   <= {1'b1, shreg[9:1]};
          end
        end
        default: ;
      endcase
      if (timed_state) to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int CLKFREQ_KHZ = 1000;
  localparam int INHIBIT_US  = 200;
  localparam int TIMEOUT_MS  = 3;
  localparam int INH_CYC     = CLKFREQ_KHZ * INHIBIT_US / 1000;
  localparam int TO_CYC      = CLKFREQ_KHZ * TIMEOUT_MS;
  localparam int HALF        = 25;
  localparam int ACK_LAT     = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2clk_oe, ps2data_oe, busy, done, error;
  logic       ps2clk_in, ps2data_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2clk_in  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_in = ~(ps2data_oe | dev_data_low);

  ps2_host_tx #(
    .CLKFREQ_KHZ(CLKFREQ_KHZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2clk_in (ps2clk_in),
    .ps2data_in(ps2data_in),
    .ps2clk_oe (ps2clk_oe),
    .ps2data_oe(ps2data_oe),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame as the device sees it on rising edges: start, D0..D7, odd parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device model: observes inhibit and request, then clocks npulses pulses.
  // Pulse 12 (index 11) is the ACK pulse; with ack set the device holds data low across it.
  task automatic dev_frame(input int npulses, input bit ack, input int glitch_at, input bit poke,
                           output logic [10:0] bits, output int req_cyc, output int ack_fall_cyc);
    int n;
    bit data_seen;
    bits = '1;
    req_cyc = 0;
    ack_fall_cyc = 0;
    n = 0;
    while (!ps2clk_oe && n < 50) begin @(negedge clk); n++; end
    check_eq("inhibit_start", ps2clk_oe, 1);
    n = 0;
    data_seen = 0;
    while (ps2clk_oe && n < INH_CYC + 50) begin
      if (ps2data_oe) data_seen = 1;
      @(negedge clk);
      n++;
    end
    check_eq("inhibit_len", n, INH_CYC);
    check_eq("inhibit_data_released", data_seen, 0);
    check_eq("req_data_oe", ps2data_oe, 1);
    check_eq("req_clk_oe", ps2clk_oe, 0);
    check_eq("req_busy", busy, 1);
    req_cyc = cyc;
    if (npulses == 0) return;
    repeat (30) @(negedge clk);
    for (int i = 0; i < npulses; i++) begin
      if (i == 11 && ack) dev_data_low = 1'b1;
      if (i == 11) ack_fall_cyc = cyc;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i < 11) bits[i] = ps2data_in;
      if (i == glitch_at) begin
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - HALF / 2 - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (poke && i == 3) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, input int bound);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < bound) begin @(negedge clk); n++; end
    check_eq("end_within_bound", (n < bound), 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic run_ack_frame(input string tag, input logic [7:0] d, input int glitch_at, input bit poke);
    logic [10:0] bits;
    int req_c, fall_c, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d);
    dev_frame(12, 1'b1, glitch_at, poke, bits, req_c, fall_c);
    wait_end(d0, e0, 200);
    check_eq({tag, "_bits"}, bits, exp_frame(d));
    check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
    check_eq({tag, "_error_pulses"}, err_cnt - e0, 0);
    check_eq({tag, "_busy_after"}, busy, 0);
    check_eq({tag, "_pads_after"}, {ps2clk_oe, ps2data_oe}, 2'b00);
  endtask

  initial begin
    logic [10:0] bits;
    int req_c, fall_c, d0, e0;
    logic [7:0] rnd;

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {ps2clk_oe, ps2data_oe, busy, done, error}, 5'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_outputs", {ps2clk_oe, ps2data_oe, busy, done, error}, 5'b0);

    run_ack_frame("ed", 8'hED, -1, 1'b0);
    run_ack_frame("f4", 8'hF4, -1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      rnd = 8'($urandom_range(0, 255));
      run_ack_frame("rand", rnd, -1, 1'b0);
    end

    // Glitch on clock during SEND and a second start while busy.
    run_ack_frame("glitch_poke", 8'hED, 4, 1'b1);

    // Device clocks the whole frame but never ACKs.
    rnd = 8'($urandom_range(0, 255));
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(rnd);
    dev_frame(12, 1'b0, -1, 1'b0, bits, req_c, fall_c);
    wait_end(d0, e0, 200);
    check_eq("nack_bits", bits, exp_frame(rnd));
    check_eq("nack_error_pulses", err_cnt - e0, 1);
    check_eq("nack_done_pulses", done_cnt - d0, 0);
    check_eq("nack_error_latency", err_cyc - fall_c, ACK_LAT);
    check_eq("nack_pads", {ps2clk_oe, ps2data_oe}, 2'b00);
    check_eq("nack_busy", busy, 0);

    // Device never clocks after the request.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h3C);
    dev_frame(0, 1'b0, -1, 1'b0, bits, req_c, fall_c);
    wait_end(d0, e0, TO_CYC + 100);
    check_eq("timeout_error_pulses", err_cnt - e0, 1);
    check_eq("timeout_latency", err_cyc - req_c, TO_CYC);
    check_eq("timeout_data_oe", ps2data_oe, 0);
    check_eq("timeout_busy", busy, 0);

    // Asynchronous reset while D4 of 0xED (a 0) is on the line.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hED);
    dev_frame(6, 1'b0, -1, 1'b0, bits, req_c, fall_c);
    check_eq("pre_reset_data_oe", ps2data_oe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("reset_async_pads", {ps2clk_oe, ps2data_oe}, 2'b00);
    check_eq("reset_flags", {busy, done, error}, 3'b000);
    repeat (4) @(negedge clk);
    check_eq("reset_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_ack_frame("post_reset_f4", 8'hF4, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte from the core to a keyboard or mouse, e.g. LED set 0xED or mouse enable 0xF4.
- Works alongside the existing PS/2 receivers on clkps2/dataps2 and mouseclk/mousedata. One instance per port.
- Drives the bus open-drain through active-high pull-low enables. The top level maps these onto the inout pads.
- Reports completion, device ACK and timeout to the controlling logic.

Parameters:
- CLKFREQ_KHZ, 28000, system clock frequency in kHz.
- INHIBIT_US, 100, time the host holds the clock low before requesting to send.
- TIMEOUT_MS, 15, maximum time from request-to-send to end of frame.

Ports:
- clk  in  1  system clock (28 MHz sysclk domain).
- rst_n  in  1  asynchronous active-low reset.
- ps2clk_in  in  1  raw PS/2 clock pad level, asynchronous.
- ps2data_in  in  1  raw PS/2 data pad level, asynchronous.
- ps2clk_oe  out  1  1 = pull clock pad low, 0 = release.
- ps2data_oe  out  1  1 = pull data pad low, 0 = release.
- tx_data  in  8  byte to send; sampled on the accepted tx_start.
- tx_start  in  1  single-cycle request; honoured only in IDLE.
- busy  out  1  high from the accepted start until return to IDLE.
- done  out  1  1-cycle pulse: frame sent and ACK received.
- error  out  1  1-cycle pulse: ACK missing or timeout.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, both pads released. Asserting rst_n low mid-frame releases both pads immediately.
- Input conditioning:
  - ps2clk_in and ps2data_in each pass through a 2-flop synchroniser.
  - Clock then passes a glitch filter: the filtered level changes only after 8 consecutive equal samples.
  - fall = 1-cycle pulse on a filtered high-to-low transition.
- Derived constants:
  - INH_CYC = CLKFREQ_KHZ*INHIBIT_US/1000 (2800 at defaults).
  - TO_CYC = CLKFREQ_KHZ*TIMEOUT_MS (420000 at defaults).
  - Counters sized with $clog2.
- Parity: odd, computed once at accept as ~^tx_data.
- FSM states and transitions:
  - IDLE: on tx_start, latch tx_data and parity, set busy, go to INHIBIT. tx_start in any other state is ignored (no queueing).
  - INHIBIT: ps2clk_oe=1, ps2data_oe=0 for INH_CYC cycles, then go to REQ.
  - REQ: ps2data_oe=1 (start bit 0), ps2clk_oe=0. Clear the timeout counter and clear bitcnt. On fall, go to SEND.
  - SEND: on each fall, drive the next bit. ps2data_oe = ~bit, so a 0 pulls low and a 1 releases.
    - Falls 1..8: data bits D0..D7, LSB first.
    - Fall 9: parity bit.
    - Fall 10: release data (stop bit); go to ACK.
  - ACK: on the next fall, sample filtered data.
    - Data 0: go to WAIT_IDLE.
    - Data 1: go to FAIL.
  - WAIT_IDLE: wait until the filtered clock and the synchronised data are both high, then pulse done and go to IDLE.
  - FAIL: release both pads, pulse error, go to IDLE.
- Timeout: the counter runs in REQ, SEND, ACK and WAIT_IDLE. Reaching TO_CYC forces FAIL from any of these states.
- A fall and a timeout in the same cycle: timeout wins.
- busy drops in the same cycle that done or error pulses.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum.
  - PS2_FILTER_LEN = 8.
  - Frame bit count constant = 11.
- Sub-module ps2_line_filter: synchroniser, glitch filter and fall detector. Reusable by the existing PS/2 receivers. Instantiated once for clock; data uses the synchroniser only.

Test Plan:
- Device model clocks at 12.5 kHz, ACKs; send tx_data=0xED.
  - Clock held low 2800 cycles first, then data low with clock released.
  - Device samples on rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - ACK low, then done pulse, busy low.
- Send 0xF4 with ACK.
  - Data bits 0,0,1,0,1,1,1,1, parity 0.
  - done pulses once, error stays 0.
- Device clocks the full frame but holds data high at the ACK fall.
  - error pulses one cycle after that fall.
  - Both pads released, busy low.
- Device never clocks after the request.
  - error at exactly 420000 cycles after REQ entry.
  - ps2data_oe returns to 0.
- Glitch and start-while-busy:
  - A 3-cycle low glitch on the clock during SEND does not advance bitcnt.
  - A second tx_start with 0x55 during the frame is ignored; the frame content stays 0xED.
- rst_n asserted low at data bit 4.
  - Both oe go to 0 asynchronously, busy/done/error stay 0.
  - After release, a new 0xF4 frame completes normally.
